// File: rtl/mmcm_seq_pkg.sv
// Shared types for the pixel-clock MMCM reset sequencer: FSM state encoding and
// the retry counter width with its saturating increment.
package mmcm_seq_pkg;

    typedef enum logic [2:0] {
        ASSERT,
        WAIT_LOCK,
        STABLE,
        RUN,
        FAULT
    } state_t;

    localparam int RETRY_W = 4;
    localparam logic [RETRY_W-1:0] RETRY_MAX = '1;

    function automatic logic [RETRY_W-1:0] retry_inc(input logic [RETRY_W-1:0] r);
        return (r == RETRY_MAX) ? r : r + 1'b1;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic 1-bit two-flop synchronizer for an asynchronous level input,
// with synchronous active-high reset to 0.
module sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    // NOTE: both flops use non-blocking assignments so q sees the previous meta, giving two stages.
    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/mmcm_reset_sequencer.sv
// Reset/lock handshake for the pixel-clock MMCM: pulses MMCM reset, waits for lock
// with timeout, qualifies lock stability, then releases sys_reset. Define
// MMCM_SEQ_FAULT_EN to enable the MAX_RETRIES limit and the FAULT state.
module mmcm_reset_sequencer
    import mmcm_seq_pkg::*;
#(
    parameter int RST_PULSE_CYCLES    = 16,
    parameter int LOCK_TIMEOUT_CYCLES = 100000,
    parameter int LOCK_STABLE_CYCLES  = 1024
`ifdef MMCM_SEQ_FAULT_EN
    ,
    parameter int MAX_RETRIES         = 3
`endif
) (
    input  logic               clk_in1,
    input  logic               reset,
    input  logic               restart,
    input  logic               mmcm_locked,
    output logic               mmcm_reset,
    output logic               sys_reset,
    output logic               ready,
    output logic               fault,
    output logic [RETRY_W-1:0] retry_count
);

    // One shared counter sized for the longest of the three waits.
    localparam int CNT_MAX_A = (RST_PULSE_CYCLES > LOCK_TIMEOUT_CYCLES) ? RST_PULSE_CYCLES
                                                                          : LOCK_TIMEOUT_CYCLES;
    localparam int CNT_MAX   = (CNT_MAX_A > LOCK_STABLE_CYCLES) ? CNT_MAX_A : LOCK_STABLE_CYCLES;
    localparam int CNT_W     = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] PULSE_LAST   = CNT_W'(RST_PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);

    state_t             state;
    state_t             state_nx;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_nx;
    logic [RETRY_W-1:0] retry_nx;
    logic               locked_s;
    logic               mmcm_reset_nx;
    logic               sys_reset_nx;
    logic               ready_nx;
    logic               fault_nx;

    sync_2ff u_lock_sync (
        .clk   (clk_in1),
        .reset (reset),
        .d     (mmcm_locked),
        .q     (locked_s)
    );

    // NOTE: every signal written here gets a default first, so no path leaves a latch behind.
    always_comb begin
        state_nx = state;
        retry_nx = retry_count;

        case (state)
            ASSERT: begin
                if (cnt == PULSE_LAST) state_nx = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                if (locked_s) begin
                    state_nx = STABLE;
                end else if (cnt == TIMEOUT_LAST) begin
                    retry_nx = retry_inc(retry_count);
`ifdef MMCM_SEQ_FAULT_EN
                    state_nx = (int'(retry_nx) == MAX_RETRIES) ? FAULT : ASSERT;
`else
                    state_nx = ASSERT;
`endif
                end
            end
            STABLE: begin
                // Any unlocked sample drops back for a fresh wait without counting a retry.
                if (!locked_s)                 state_nx = WAIT_LOCK;
                else if (cnt == STABLE_LAST)   state_nx = RUN;
            end
            RUN: begin
                if (!locked_s) state_nx = ASSERT;
            end
`ifdef MMCM_SEQ_FAULT_EN
            FAULT: begin
                state_nx = FAULT;
            end
`endif
            default: begin
                state_nx = ASSERT;
            end
        endcase

        if (restart) begin
            state_nx = ASSERT;
            retry_nx = '0;
        end

        if (state_nx == RUN && state != RUN) retry_nx = '0;

        // A restart re-enters ASSERT even from ASSERT, so it also clears the count.
        if (restart || state_nx != state) begin
            cnt_nx = '0;
        end else if (state == RUN || state == FAULT) begin
            cnt_nx = cnt;
        end else begin
            cnt_nx = cnt + 1'b1;
        end

        ready_nx     = (state_nx == RUN);
        sys_reset_nx = (state_nx != RUN);
`ifdef MMCM_SEQ_FAULT_EN
        fault_nx      = (state_nx == FAULT);
        mmcm_reset_nx = (state_nx == ASSERT) || (state_nx == FAULT);
`else
        fault_nx      = 1'b0;
        mmcm_reset_nx = (state_nx == ASSERT);
`endif
    end

    always_ff @(posedge clk_in1) begin
        if (reset) begin
            state       <= ASSERT;
            cnt         <= '0;
            retry_count <= '0;
            mmcm_reset  <= 1'b1;
            sys_reset   <= 1'b1;
            ready       <= 1'b0;
            fault       <= 1'b0;
        end else begin
            state       <= state_nx;
            cnt         <= cnt_nx;
            retry_count <= retry_nx;
            mmcm_reset  <= mmcm_reset_nx;
            sys_reset   <= sys_reset_nx;
            ready       <= ready_nx;
            fault       <= fault_nx;
        end
    end

endmodule

// File: tb/tb_mmcm_reset_sequencer.sv
// Self-checking bench for mmcm_reset_sequencer: a hand-derived vector table, hand-written
// timeout/fault/restart sequences, and randomized stimulus against a behavioural model.
module tb_mmcm_reset_sequencer;

    localparam int RST_PULSE    = 4;
    localparam int LOCK_TIMEOUT = 20;
    localparam int LOCK_STABLE  = 8;
    localparam int MAX_RETRIES  = 2;
`ifdef MMCM_SEQ_FAULT_EN
    localparam bit FAULT_EN = 1'b1;
`else
    localparam bit FAULT_EN = 1'b0;
`endif

    // Model phases: reset pulse, waiting for lock, qualifying lock, running, faulted.
    localparam int PH_PULSE = 10;
    localparam int PH_WAIT  = 11;
    localparam int PH_QUAL  = 12;
    localparam int PH_RUN   = 13;
    localparam int PH_FAULT = 14;

    logic       clk_in1 = 1'b0;
    logic       reset = 1'b1;
    logic       restart = 1'b0;
    logic       mmcm_locked = 1'b0;
    logic       mmcm_reset;
    logic       sys_reset;
    logic       ready;
    logic       fault;
    logic [3:0] retry_count;

    int errors = 0;
    int checks = 0;

    int m_phase = PH_PULSE;
    int m_since = 0;
    int m_retry = 0;
    bit m_s1 = 1'b0;
    bit m_s2 = 1'b0;
    int run_left = 0;

    typedef struct {
        bit rst;
        bit rs;
        bit lk;
        int n;
        bit e_mm;
        bit e_sys;
        bit e_rdy;
        bit e_flt;
        int e_retry;
    } vec_t;

    vec_t vecs[$];

    always #5 clk_in1 = ~clk_in1;

    mmcm_reset_sequencer #(
        .RST_PULSE_CYCLES    (RST_PULSE),
        .LOCK_TIMEOUT_CYCLES (LOCK_TIMEOUT),
        .LOCK_STABLE_CYCLES  (LOCK_STABLE)
`ifdef MMCM_SEQ_FAULT_EN
        ,
        .MAX_RETRIES         (MAX_RETRIES)
`endif
    ) dut (
        .clk_in1     (clk_in1),
        .reset       (reset),
        .restart     (restart),
        .mmcm_locked (mmcm_locked),
        .mmcm_reset  (mmcm_reset),
        .sys_reset   (sys_reset),
        .ready       (ready),
        .fault       (fault),
        .retry_count (retry_count)
    );

    // Behavioural model advanced once per rising edge using the inputs the DUT sampled.
    task automatic model_edge();
        bit seen;
        int nxt;
        if (reset) begin
            m_phase = PH_PULSE;
            m_since = 0;
            m_retry = 0;
            m_s1    = 1'b0;
            m_s2    = 1'b0;
            return;
        end
        seen = m_s2;
        nxt  = m_phase;
        if (m_phase == PH_PULSE && m_since + 1 == RST_PULSE) begin
            nxt = PH_WAIT;
        end else if (m_phase == PH_WAIT) begin
            if (seen) begin
                nxt = PH_QUAL;
            end else if (m_since + 1 == LOCK_TIMEOUT) begin
                m_retry = (m_retry < 15) ? m_retry + 1 : 15;
                nxt = (FAULT_EN && m_retry == MAX_RETRIES) ? PH_FAULT : PH_PULSE;
            end
        end else if (m_phase == PH_QUAL) begin
            if (!seen)                          nxt = PH_WAIT;
            else if (m_since + 1 == LOCK_STABLE) nxt = PH_RUN;
        end else if (m_phase == PH_RUN && !seen) begin
            nxt = PH_PULSE;
        end
        if (restart) begin
            nxt     = PH_PULSE;
            m_retry = 0;
        end
        if (nxt == PH_RUN) m_retry = 0;
        m_since = (restart || nxt != m_phase) ? 0 : m_since + 1;
        m_phase = nxt;
        m_s2 = m_s1;
        m_s1 = mmcm_locked;
    endtask

    task automatic tick();
        @(posedge clk_in1);
        model_edge();
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check(input string name, input logic [7:0] actual, input logic [7:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic check_outs(input string tag, input bit mm, input bit sys, input bit rdy,
                              input bit flt, input int retry);
        check({tag, ".mmcm_reset"}, 8'(mmcm_reset), 8'(mm));
        check({tag, ".sys_reset"}, 8'(sys_reset), 8'(sys));
        check({tag, ".ready"}, 8'(ready), 8'(rdy));
        check({tag, ".fault"}, 8'(fault), 8'(flt));
        check({tag, ".retry_count"}, 8'(retry_count), 8'(retry));
    endtask

    initial begin
        // Clean start, lock loss in RUN, and a 2-cycle lock glitch during qualification.
        vecs.push_back('{1, 0, 0, 1,  1, 1, 0, 0, 0});
        vecs.push_back('{0, 0, 0, 3,  1, 1, 0, 0, 0});
        vecs.push_back('{0, 0, 0, 1,  0, 1, 0, 0, 0});
        vecs.push_back('{0, 0, 1, 10, 0, 1, 0, 0, 0});
        vecs.push_back('{0, 0, 1, 1,  0, 0, 1, 0, 0});
        vecs.push_back('{0, 0, 1, 5,  0, 0, 1, 0, 0});
        vecs.push_back('{0, 0, 0, 2,  0, 0, 1, 0, 0});
        vecs.push_back('{0, 0, 0, 1,  1, 1, 0, 0, 0});
        vecs.push_back('{0, 0, 0, 3,  1, 1, 0, 0, 0});
        vecs.push_back('{0, 0, 0, 1,  0, 1, 0, 0, 0});
        vecs.push_back('{0, 0, 1, 4,  0, 1, 0, 0, 0});
        vecs.push_back('{0, 0, 0, 2,  0, 1, 0, 0, 0});
        vecs.push_back('{0, 0, 1, 10, 0, 1, 0, 0, 0});
        vecs.push_back('{0, 0, 1, 1,  0, 0, 1, 0, 0});

        foreach (vecs[i]) begin
            reset       = vecs[i].rst;
            restart     = vecs[i].rs;
            mmcm_locked = vecs[i].lk;
            for (int c = 0; c < vecs[i].n; c++) begin
                tick();
                check_outs($sformatf("vec%0d.%0d", i, c), vecs[i].e_mm, vecs[i].e_sys,
                           vecs[i].e_rdy, vecs[i].e_flt, vecs[i].e_retry);
            end
        end

        // Lock never arrives: one attempt is 4 pulse cycles plus 20 wait cycles.
        reset = 1'b1; restart = 1'b0; mmcm_locked = 1'b0;
        tick();
        reset = 1'b0;
        run(23); check_outs("pre_timeout1", 0, 1, 0, 0, 0);
        run(1);  check_outs("timeout1", 1, 1, 0, 0, 1);
        run(23); check_outs("pre_timeout2", 0, 1, 0, 0, 1);
        run(1);
`ifdef MMCM_SEQ_FAULT_EN
        check_outs("fault_entry", 1, 1, 0, 1, 2);
        run(50); check_outs("fault_hold", 1, 1, 0, 1, 2);
`else
        check_outs("timeout2", 1, 1, 0, 0, 2);
        run(312); check_outs("retry15", 1, 1, 0, 0, 15);
        run(4);   check_outs("retry15_wait", 0, 1, 0, 0, 15);
        run(20);  check_outs("retry_saturated", 1, 1, 0, 0, 15);
`endif

        // Restart pulse: fresh 4-cycle pulse with the retry count cleared.
        restart = 1'b1;
        tick();
        restart = 1'b0;
        check_outs("restart", 1, 1, 0, 0, 0);
        run(3); check_outs("restart_pulse_end", 1, 1, 0, 0, 0);
        run(1); check_outs("restart_wait", 0, 1, 0, 0, 0);
        run(20); check_outs("restart_timeout", 1, 1, 0, 0, 1);
        run(2);

        // Reset and restart in the same cycle: reset values, then a normal pulse.
        reset = 1'b1; restart = 1'b1;
        tick();
        reset = 1'b0; restart = 1'b0;
        check_outs("reset_and_restart", 1, 1, 0, 0, 0);
        run(3); check_outs("rr_pulse_end", 1, 1, 0, 0, 0);
        run(1); check_outs("rr_wait", 0, 1, 0, 0, 0);

        // Randomized lock behaviour with occasional restarts and resets.
        reset = 1'b1;
        tick();
        for (int c = 0; c < 4000; c++) begin
            reset   = ($urandom_range(0, 599) == 0);
            restart = ($urandom_range(0, 149) == 0);
            if (run_left == 0) begin
                mmcm_locked = ~mmcm_locked;
                run_left    = $urandom_range(1, 70);
            end
            run_left--;
            tick();
            check_outs($sformatf("rnd%0d", c),
                       (m_phase == PH_PULSE) || (m_phase == PH_FAULT),
                       m_phase != PH_RUN,
                       m_phase == PH_RUN,
                       m_phase == PH_FAULT,
                       m_retry);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
